des_key_sched: RTL and testbench

- Sequential DES round-key generator. Accepts one 64-bit key and emits the 16 round subkeys (48 bits each), one per accepted output beat.
- Runs in either direction:
  - encrypt order K1..K16, using left rotations;
  - decrypt order K16..K1, using right rotations.
- Sits between the key-load interface and the round datapath. It replaces the precomputed 16-key array with a streaming valid/ready source.

---
 rtl/des_pkg.sv | 56 +++++
 rtl/key_perm1.sv | 21 ++
 rtl/key_perm2.sv | 21 ++
 rtl/des_key_sched.sv | 180 ++++++++++++++++++
 tb/tb_des_key_sched.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared constants, enums, permutation tables and shift schedule for the
// DES key scheduler. Bit positions in tables use DES numbering (1 = MSB).
package des_pkg;

  localparam int KEY_W = 64;
  localparam int CD_W  = 28;
  localparam int SK_W  = 48;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } dir_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // PC-1: 56 entries, C half first then D half.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: positions into the 56-bit {C,D}.
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Rotation amount for round r (1..16).
  function automatic logic [1:0] shifts(
    input logic [4:0] r
  );
    logic [1:0] s;
    case (r)
      5'd1, 5'd2,
      5'd9, 5'd16: s = 2'd1;
      default:     s = 2'd2;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/key_perm1.sv
// PC-1: selects the 56 key bits (dropping parity) into {C0,D0}.
// Ports: i_key (64-bit DES key, MSB = bit 1), o_cd (C0 in [55:28], D0 in [27:0]).
module key_perm1
  import des_pkg::*;
(
  input  logic [KEY_W-1:0]  i_key,
  output logic [2*CD_W-1:0] o_cd
);

  for (genvar g = 0; g < 2*CD_W; g++) begin : g_bit
    assign o_cd[2*CD_W-1-g] = i_key[KEY_W-PC1_TAB[g]];
  end

  // Parity bits 8,16,..,64 never reach the schedule.
  logic w_unused_parity;
  assign w_unused_parity = ^{i_key[56], i_key[48],
                             i_key[40], i_key[32],
                             i_key[24], i_key[16],
                             i_key[8],  i_key[0]};

endmodule

// File: rtl/key_perm2.sv
// PC-2: compresses {C,D} (56 bits) into one 48-bit round subkey.
// Ports: i_cd ({C,D}, MSB = bit 1), o_sk (subkey, MSB = bit 1).
module key_perm2
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0] i_cd,
  output logic [SK_W-1:0]   o_sk
);

  for (genvar g = 0; g < SK_W; g++) begin : g_bit
    assign o_sk[SK_W-1-g] = i_cd[2*CD_W-PC2_TAB[g]];
  end

  // Positions 9,18,22,25,35,38,43,54 are dropped by PC-2.
  logic w_unused_drop;
  assign w_unused_drop = ^{i_cd[47], i_cd[38],
                           i_cd[34], i_cd[31],
                           i_cd[21], i_cd[18],
                           i_cd[13], i_cd[2]};

endmodule

// File: rtl/des_key_sched.sv
// Streaming DES round-key generator: one key in, 16 subkeys out (K1..K16
// encrypt, K16..K1 decrypt) over a valid/ready handshake.
// Ports: clk/rst (sync, active high); key_in/decrypt/key_valid/key_ready
// key load; subkey_out/subkey_round/subkey_last/subkey_valid/subkey_ready
// subkey stream.
module des_key_sched #(
  parameter int KEY_W = 64,
  parameter int SK_W  = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             decrypt,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [SK_W-1:0]  subkey_out,
  output logic [3:0]       subkey_round,
  output logic             subkey_last,
  output logic             subkey_valid,
  input  logic             subkey_ready
);

  import des_pkg::*;

  state_e            r_state;
  dir_e              r_dir;
  logic [CD_W-1:0]   r_c;
  logic [CD_W-1:0]   r_d;
  logic [4:0]        r_cnt;
  logic              r_key_ready;
  logic              r_valid;
  logic              r_last;
  logic [3:0]        r_round;
  logic [SK_W-1:0]   r_sk;

  logic [2*CD_W-1:0] w_cd0;
  logic [CD_W-1:0]   w_c0;
  logic [CD_W-1:0]   w_d0;
  logic [CD_W-1:0]   w_c_nx;
  logic [CD_W-1:0]   w_d_nx;
  logic [SK_W-1:0]   w_sk_nx;
  logic              w_load;
  logic              w_adv;
  logic              w_enc_adv;
  logic              w_dec_adv;
  logic [4:0]        w_idx;
  logic              w_two;

  function automatic logic [CD_W-1:0] rotl(
    input logic [CD_W-1:0] x,
    input logic            two
  );
    return two ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]}
               : {x[CD_W-2:0], x[CD_W-1]};
  endfunction

  function automatic logic [CD_W-1:0] rotr(
    input logic [CD_W-1:0] x,
    input logic            two
  );
    return two ? {x[1:0], x[CD_W-1:2]}
               : {x[0], x[CD_W-1:1]};
  endfunction

  key_perm1 u_pc1 (
    .i_key (key_in),
    .o_cd  (w_cd0)
  );

  assign w_c0 = w_cd0[2*CD_W-1:CD_W];
  assign w_d0 = w_cd0[CD_W-1:0];

  assign w_load = (r_state == IDLE) & key_valid;
  assign w_adv  = (r_state == RUN) & subkey_ready
                & (r_cnt != 5'd16);
  assign w_enc_adv = w_adv & (r_dir == ENC);
  assign w_dec_adv = w_adv & (r_dir == DEC);

  // Encrypt steps forward through the table; decrypt undoes the shift
  // that produced the current round, walking the table backwards.
  assign w_idx = (r_dir == ENC) ? r_cnt + 5'd1
                                : 5'd17 - r_cnt;
  assign w_two = (shifts(w_idx) == 2'd2);

  always_comb begin
    w_c_nx = r_c;
    w_d_nx = r_d;
    unique case (1'b1)
      w_load & ~decrypt: begin
        w_c_nx = rotl(w_c0, 1'b0);
        w_d_nx = rotl(w_d0, 1'b0);
      end
      w_load & decrypt: begin
        // Full 28-bit cycle means C16/D16 equal C0/D0.
        w_c_nx = w_c0;
        w_d_nx = w_d0;
      end
      w_enc_adv: begin
        w_c_nx = rotl(r_c, w_two);
        w_d_nx = rotl(r_d, w_two);
      end
      w_dec_adv: begin
        w_c_nx = rotr(r_c, w_two);
        w_d_nx = rotr(r_d, w_two);
      end
      default: begin
        w_c_nx = r_c;
        w_d_nx = r_d;
      end
    endcase
  end

  key_perm2 u_pc2 (
    .i_cd ({w_c_nx, w_d_nx}),
    .o_sk (w_sk_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dir       <= ENC;
      r_c         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_key_ready <= 1'b1;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_round     <= '0;
      r_sk        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (key_valid) begin
            r_state     <= RUN;
            r_dir       <= dir_e'(decrypt);
            r_c         <= w_c_nx;
            r_d         <= w_d_nx;
            r_cnt       <= 5'd1;
            r_sk        <= w_sk_nx;
            r_round     <= decrypt ? 4'd15 : 4'd0;
            r_last      <= 1'b0;
            r_valid     <= 1'b1;
            r_key_ready <= 1'b0;
          end
        end
        RUN: begin
          if (subkey_ready) begin
            if (r_cnt == 5'd16) begin
              r_state     <= IDLE;
              r_valid     <= 1'b0;
              r_last      <= 1'b0;
              r_key_ready <= 1'b1;
            end else begin
              r_c     <= w_c_nx;
              r_d     <= w_d_nx;
              r_cnt   <= r_cnt + 5'd1;
              r_sk    <= w_sk_nx;
              r_last  <= (r_cnt == 5'd15);
              r_round <= (r_dir == ENC)
                       ? r_round + 4'd1
                       : r_round - 4'd1;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_valid     <= 1'b0;
          r_key_ready <= 1'b1;
        end
      endcase
    end
  end

  assign key_ready    = r_key_ready;
  assign subkey_valid = r_valid;
  assign subkey_last  = r_last;
  assign subkey_round = r_round;
  assign subkey_out   = r_sk;

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: directed known-answer runs plus a
// random sweep against a cumulative-rotation DES key schedule model.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        decrypt;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] subkey_out;
  logic [3:0]  subkey_round;
  logic        subkey_last;
  logic        subkey_valid;
  logic        subkey_ready;

  always #5 clk = ~clk;

  des_key_sched dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .subkey_out   (subkey_out),
    .subkey_round (subkey_round),
    .subkey_last  (subkey_last),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready)
  );

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [47:0] KA1   = 48'h1B02EFFC7072;
  localparam logic [47:0] KA2   = 48'h79AED9DBC9E5;
  localparam logic [47:0] KA16  = 48'hCB3D8B0E17F5;

  int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  int SH [17] = '{0, 1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  rnd;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t held;
  bit    hold_v     = 0;
  bit    want_first = 0;
  bit    want_idle  = 0;
  bit    want_rst   = 0;
  int    n_acc      = 0;
  int    n_cmp      = 0;
  int    n_err      = 0;

  function automatic logic [27:0] rot28(input logic [27:0] x, input int s);
    logic [27:0] r;
    r = (x << s) | (x >> (28 - s));
    return r;
  endfunction

  // K_r from the rule: C_r/D_r = C0/D0 rotated left by sum(SH[1..r]).
  function automatic logic [47:0] model(input logic [63:0] k, input int r);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] ks;
    int tot;
    c = '0; d = '0; ks = '0; tot = 0;
    for (int i = 0; i < 28; i++) begin
      c = {c[26:0], k[64 - PC1[i]]};
      d = {d[26:0], k[64 - PC1[28 + i]]};
    end
    for (int i = 1; i <= r; i++) tot += SH[i];
    cd = {rot28(c, tot % 28), rot28(d, tot % 28)};
    for (int i = 0; i < 48; i++) ks = {ks[46:0], cd[56 - PC2[i]]};
    return ks;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [63:0] k, input logic dec);
    beat_t b;
    for (int i = 0; i < 16; i++) begin
      int r;
      r = dec ? 16 - i : i + 1;
      b.sk   = model(k, r);
      b.rnd  = 4'(r - 1);
      b.last = (i == 15);
      exp_q.push_back(b);
    end
  endtask

  // Per-cycle compare against the scoreboard, sampled at the falling edge.
  task automatic monitor();
    if (rst) begin
      exp_q.delete();
      hold_v = 0; want_first = 0; want_idle = 0; want_rst = 1;
      return;
    end
    if (want_rst) begin
      chk("rst_state", {subkey_out, subkey_round, subkey_last,
                        subkey_valid, key_ready}, 64'h1);
      want_rst = 0;
    end
    if (want_first) begin
      chk("latency", subkey_valid, 1);
      want_first = 0;
    end
    if (want_idle) begin
      chk("idle_after_last", {subkey_valid, key_ready}, 2'b01);
      want_idle = 0;
    end
    chk("ready_vs_valid", key_ready, !subkey_valid);
    if (hold_v)
      chk("stall_hold", {subkey_out, subkey_round, subkey_last, subkey_valid},
          {held, 1'b1});
    hold_v = 0;
    if (subkey_valid) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", subkey_valid, 0);
      end else begin
        chk("subkey", subkey_out, exp_q[0].sk);
        chk("round",  subkey_round, exp_q[0].rnd);
        chk("last",   subkey_last, exp_q[0].last);
        if (subkey_ready) begin
          if (exp_q[0].last) want_idle = 1;
          void'(exp_q.pop_front());
        end else begin
          hold_v = 1;
          held = {subkey_out, subkey_round, subkey_last};
        end
      end
    end
    if (key_valid && key_ready) begin
      push(key_in, decrypt);
      want_first = 1;
      n_acc++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!key_ready && t < 50) begin tick(); t++; end
    chk("wait_key_ready", key_ready, 1);
  endtask

  task automatic drain(input bit rnd);
    int t = 0;
    while ((exp_q.size() != 0 || want_idle) && t < 400) begin
      subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      t++;
    end
    chk("drain", exp_q.size(), 0);
    subkey_ready = 1'b1;
  endtask

  task automatic run(input logic [63:0] k, input logic dec, input bit rnd);
    wait_ready();
    key_in = k; decrypt = dec; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_in = {$urandom, $urandom};
    decrypt = 1'($urandom_range(0, 1));
    drain(rnd);
  endtask

  initial begin
    int t;
    logic [63:0] k;
    rst = 1'b1; key_in = '0; decrypt = 1'b0;
    key_valid = 1'b0; subkey_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Pin the model to the published schedule.
    chk("model_k1",  model(KEY_A, 1),  KA1);
    chk("model_k2",  model(KEY_A, 2),  KA2);
    chk("model_k16", model(KEY_A, 16), KA16);

    // Encrypt known answer, full rate.
    key_in = KEY_A; decrypt = 1'b0; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("enc_k1", {subkey_valid, subkey_round, subkey_out}, {1'b1, 4'd0, KA1});
    tick();
    chk("enc_k2", subkey_out, KA2);
    repeat (14) tick();
    chk("enc_k16", {subkey_last, subkey_round, subkey_out}, {1'b1, 4'd15, KA16});
    tick();
    chk("enc_done", {key_ready, subkey_valid}, 2'b10);
    tick();

    // Decrypt known answer.
    key_in = KEY_A; decrypt = 1'b1; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("dec_first", {subkey_round, subkey_out}, {4'd15, KA16});
    repeat (15) tick();
    chk("dec_last", {subkey_last, subkey_round, subkey_out}, {1'b1, 4'd0, KA1});
    tick();
    tick();

    // Backpressure.
    run(KEY_A, 1'b0, 1'b1);
    run(KEY_A, 1'b1, 1'b1);

    // key_valid held through RUN with a different key.
    wait_ready();
    t = n_acc;
    key_in = KEY_A; decrypt = 1'b0; key_valid = 1'b1;
    tick();
    key_in = 64'h0E329232EA6D0D73;
    t = 0;
    while (n_acc < 2 + 0 && t < 100) begin tick(); t++; end
    t = 0;
    while (!key_ready && t < 100) begin tick(); t++; end
    tick();
    key_valid = 1'b0;
    drain(1'b0);
    chk("held_valid_accepts", n_acc, 6);

    // Reset at the 7th beat.
    wait_ready();
    key_in = KEY_A; decrypt = 1'b0; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    t = 0;
    while (!(subkey_valid && subkey_round == 4'd6) && t < 50) begin
      tick(); t++;
    end
    chk("reach_beat7", subkey_round, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_out", {subkey_valid, key_ready, subkey_out}, {1'b0, 1'b1, 48'h0});
    key_in = KEY_A; decrypt = 1'b0; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("k1_after_rst", subkey_out, KA1);
    drain(1'b0);

    // Random sweep, both directions.
    for (int i = 0; i < 200; i++) begin
      k = {$urandom, $urandom};
      run(k, 1'b0, (i % 2) == 1);
      run(k, 1'b1, (i % 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
